deint_col_reader: RTL

//  Downstream of the deinterleaver enable generator. Writes one code block row-wise into the

---
 rtl/deint_col_reader.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/deint_col_reader.sv
`default_nettype none
// =============================================================================
// Module   : deint_col_reader
// Brief    : Stores one code block row-wise into the deinterleaver RAM, then
//            reads it back column-wise and streams it to the turbo decoder.
// Revision : 1.0 - initial release
// =============================================================================
module deint_col_reader #(
  parameter int DW   = 8,
  parameter int AW   = 16,
  parameter int COLS = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wen,
  input  logic [15:0]   enable,
  input  logic [15:0]   id_jump,
  input  logic [DW-1:0] din,
  input  logic [12:0]   m_len,
  input  logic          request,
  output logic          ram_we,
  output logic [AW-1:0] ram_waddr,
  output logic [DW-1:0] ram_wdata,
  output logic          ram_re,
  output logic [AW-1:0] ram_raddr,
  input  logic [DW-1:0] ram_rdata,
  output logic [DW-1:0] dout,
  output logic          dout_vld,
  output logic          done,
  output logic          err
);

  localparam int            CW         = $clog2(COLS);
  localparam logic [CW-1:0] C_LAST_COL = CW'(COLS - 1);
  localparam logic [AW-1:0] C_ROW_STEP = AW'(COLS);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FILL  = 2'd1,
    S_READ  = 2'd2,
    S_FLUSH = 2'd3
  } state_t;

  state_t        r_state, w_state_n;
  logic [AW-1:0] r_base, w_base_n;
  logic [AW-1:0] r_row_off, w_row_off_n;
  logic [12:0]   r_len, w_len_n;
  logic [12:0]   r_rows, w_rows_n;
  logic [12:0]   r_row, w_row_n;
  logic [12:0]   r_wr_cnt, w_wr_cnt_n;
  logic [CW-1:0] r_col, w_col_n;
  logic          r_flush, w_flush_n;
  logic          r_we, w_we_n;
  logic [AW-1:0] r_waddr;
  logic [DW-1:0] r_wdata;
  logic          r_re, w_re_n;
  logic [AW-1:0] r_raddr, w_raddr_n;
  logic          r_vld;
  logic          r_done, w_done_n;
  logic          r_err, w_err_n;
  logic          w_len_bad;
  logic [AW-1:0] w_waddr;

  // Block lengths must be a whole number of rows; zero is meaningless.
  assign w_len_bad = (m_len[CW-1:0] != '0) || (m_len == '0);
  assign w_waddr   = AW'(id_jump) + AW'(enable);

  // Next-state, counter and strobe decode.
  always_comb begin
    w_state_n   = r_state;
    w_base_n    = r_base;
    w_len_n     = r_len;
    w_rows_n    = r_rows;
    w_wr_cnt_n  = r_wr_cnt;
    w_col_n     = r_col;
    w_row_n     = r_row;
    w_row_off_n = r_row_off;
    w_flush_n   = 1'b0;
    w_we_n      = 1'b0;
    w_re_n      = 1'b0;
    w_raddr_n   = r_raddr;
    w_done_n    = 1'b0;
    w_err_n     = r_err;
    case (r_state)
      S_IDLE: begin
        if (wen) begin
          if (w_len_bad) begin
            w_err_n = 1'b1;
          end else begin
            w_we_n     = 1'b1;
            w_state_n  = S_FILL;
            w_base_n   = AW'(id_jump);
            w_len_n    = m_len;
            w_rows_n   = m_len >> CW;
            w_wr_cnt_n = 13'd1;
          end
        end
      end
      S_FILL: begin
        if (wen) begin
          w_we_n     = 1'b1;
          w_wr_cnt_n = r_wr_cnt + 13'd1;
          if (r_wr_cnt + 13'd1 == r_len) begin
            w_state_n   = S_READ;
            w_col_n     = '0;
            w_row_n     = '0;
            w_row_off_n = '0;
          end
        end
      end
      S_READ: begin
        if (wen) begin
          w_err_n = 1'b1;
        end
        if (request) begin
          w_re_n    = 1'b1;
          w_raddr_n = r_base + r_row_off + AW'(r_col);
          if (r_row == r_rows - 13'd1) begin
            w_row_n     = '0;
            w_row_off_n = '0;
            w_col_n     = r_col + 1'b1;
            if (r_col == C_LAST_COL) begin
              w_state_n = S_FLUSH;
            end
          end else begin
            w_row_n     = r_row + 13'd1;
            w_row_off_n = r_row_off + C_ROW_STEP;
          end
        end
      end
      S_FLUSH: begin
        // One cycle for the final RAM read to land, then signal completion.
        if (!r_flush) begin
          w_flush_n = 1'b1;
        end else begin
          w_done_n  = 1'b1;
          w_state_n = S_IDLE;
        end
      end
      default: w_state_n = S_IDLE;
    endcase
  end

  // State, counters and all registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_base    <= '0;
      r_len     <= '0;
      r_rows    <= '0;
      r_wr_cnt  <= '0;
      r_col     <= '0;
      r_row     <= '0;
      r_row_off <= '0;
      r_flush   <= 1'b0;
      r_we      <= 1'b0;
      r_waddr   <= '0;
      r_wdata   <= '0;
      r_re      <= 1'b0;
      r_raddr   <= '0;
      r_vld     <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_state   <= w_state_n;
      r_base    <= w_base_n;
      r_len     <= w_len_n;
      r_rows    <= w_rows_n;
      r_wr_cnt  <= w_wr_cnt_n;
      r_col     <= w_col_n;
      r_row     <= w_row_n;
      r_row_off <= w_row_off_n;
      r_flush   <= w_flush_n;
      r_we      <= w_we_n;
      if (w_we_n) begin
        r_waddr <= w_waddr;
        r_wdata <= din;
      end
      r_re      <= w_re_n;
      r_raddr   <= w_raddr_n;
      r_vld     <= r_re;
      r_done    <= w_done_n;
      r_err     <= w_err_n;
    end
  end

  assign ram_we    = r_we;
  assign ram_waddr = r_waddr;
  assign ram_wdata = r_wdata;
  assign ram_re    = r_re;
  assign ram_raddr = r_raddr;
  // RAM data arrives the cycle after ram_re; pass it through, gated by valid.
  assign dout      = r_vld ? ram_rdata : '0;
  assign dout_vld  = r_vld;
  assign done      = r_done;
  assign err       = r_err;

endmodule
`default_nettype wire
